// File: rtl/mpsoc_spram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_PORTS requesters,
// with per-port burst locking bounded by MAX_LOCK consecutive grants.
module mpsoc_spram_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_LOCK   = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_PORTS-1:0]                req_i,
  input  logic [NUM_PORTS-1:0]                we_i,
  input  logic [NUM_PORTS-1:0]                lock_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     wdata_i,
  output logic [NUM_PORTS-1:0]                gnt_o,
  output logic [NUM_PORTS-1:0]                rvalid_o,
  output logic [DATA_WIDTH-1:0]               rdata_o,
  output logic                                mem_req_o,
  output logic                                mem_we_o,
  output logic [ADDR_WIDTH-1:0]               mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]             mem_be_o,
  output logic [DATA_WIDTH-1:0]               mem_data_o,
  input  logic [DATA_WIDTH-1:0]               mem_data_i
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam int BW = DATA_WIDTH / 8;

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        lock_cnt_q, lock_cnt_d;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;

  logic                 forced;
  logic                 arb;
  logic                 found;
  logic [PW-1:0]        sel;
  logic [PW-1:0]        sel_next;
  logic [PW-1:0]        owner_next;

  // A forced release re-arbitrates in the same cycle, starting after the owner.
  assign forced = (state_q == ST_LOCKED) && (lock_cnt_q == CW'(MAX_LOCK));
  assign arb    = (state_q == ST_UNLOCKED) || forced;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    if (arb) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && req_i[(int'(rr_ptr_q) + i) % NUM_PORTS]) begin
          found = 1'b1;
          sel   = PW'((int'(rr_ptr_q) + i) % NUM_PORTS);
        end
      end
    end else begin
      sel   = owner_q;
      found = req_i[owner_q];
    end
  end

  always_comb begin
    gnt_o = '0;
    if (found) gnt_o[sel] = 1'b1;
  end

  assign sel_next   = (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + PW'(1);
  assign owner_next = (owner_q == PW'(NUM_PORTS - 1)) ? '0 : owner_q + PW'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    if (arb && found) begin
      rr_ptr_d = sel_next;
      if (lock_i[sel]) begin
        state_d    = ST_LOCKED;
        owner_d    = sel;
        lock_cnt_d = CW'(1);
      end else begin
        state_d    = ST_UNLOCKED;
        lock_cnt_d = '0;
      end
    end else if (state_q == ST_LOCKED) begin
      if (found && !forced) lock_cnt_d = lock_cnt_q + CW'(1);
      if (!lock_i[owner_q]) begin
        state_d    = ST_UNLOCKED;
        lock_cnt_d = '0;
        rr_ptr_d   = owner_next;
      end
    end
  end

  assign rvalid_d = gnt_o & ~we_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_UNLOCKED;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_be_o   = '0;
    mem_data_o = '0;
    if (found) begin
      mem_req_o  = 1'b1;
      mem_we_o   = we_i[sel];
      mem_addr_o = addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_be_o   = be_i[int'(sel)*BW +: BW];
      mem_data_o = wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = mem_data_i;

endmodule

// File: tb/tb_mpsoc_spram_arbiter.sv
// Directed bench for mpsoc_spram_arbiter: arbitration order, read return,
// burst locking, owner idle, forced release, pointer wrap and reset mid-burst.
module tb_mpsoc_spram_arbiter;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = DW / 8;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req, we, lock;
  logic [N*AW-1:0]   addr;
  logic [N*BW-1:0]   be;
  logic [N*DW-1:0]   wdata;
  logic [N-1:0]      gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic              mem_req, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [BW-1:0]     mem_be;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  int checks = 0;
  int errors = 0;

  mpsoc_spram_arbiter #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .we_i(we), .lock_i(lock),
    .addr_i(addr), .be_i(be), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_data_o(mem_wdata), .mem_data_i(mem_rdata)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency
  always @(posedge clk) begin
    if (mem_req && !mem_we)
      mem_rdata <= (mem_addr == 64'h40) ? 64'hDEAD_BEEF : ~mem_addr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to the next mid-cycle drive point
  task automatic next_cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; lock = '0;
    addr = '0; be = '0; wdata = '0; mem_rdata = '0;

    // reset state with all requesters active
    req = 4'b1111;
    next_cyc(); #1;
    chk("reset_gnt", 64'(gnt), 64'h1);
    chk("reset_rvalid", 64'(rvalid), 64'h0);

    // round robin over 8 cycles
    next_cyc(); rst = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_gnt", 64'(gnt), 64'(1) << (i % 4));
      if (i > 0) chk("rr_rvalid", 64'(rvalid), 64'(1) << ((i - 1) % 4));
      next_cyc(); #1;
    end

    // read return on port 2, then a write from port 1
    req = 4'b0100; addr[2*AW +: AW] = 64'h40; #1;
    chk("rd_gnt", 64'(gnt), 64'h4);
    chk("rd_mem_addr", mem_addr, 64'h40);
    chk("rd_mem_we", 64'(mem_we), 64'h0);
    next_cyc();
    req = 4'b0010; we = 4'b0010; addr[1*AW +: AW] = 64'h80;
    wdata[1*DW +: DW] = 64'h1234; be[1*BW +: BW] = 8'hFF; #1;
    chk("rd_rvalid", 64'(rvalid), 64'h4);
    chk("rd_rdata", rdata, 64'hDEAD_BEEF);
    chk("wr_gnt", 64'(gnt), 64'h2);
    chk("wr_mem_we", 64'(mem_we), 64'h1);
    chk("wr_mem_data", mem_wdata, 64'h1234);
    chk("wr_mem_be", 64'(mem_be), 64'hFF);
    next_cyc();
    req = '0; we = '0; #1;
    chk("wr_no_rvalid", 64'(rvalid), 64'h0);
    chk("idle_mem_req", 64'(mem_req), 64'h0);
    chk("idle_mem_addr", mem_addr, 64'h0);

    // lock hold: port 1 4-beat burst while port 3 keeps requesting
    next_cyc(); req = 4'b1000; #1;
    chk("lk_pre_gnt", 64'(gnt), 64'h8);
    for (int b = 0; b < 4; b++) begin
      next_cyc(); req = 4'b1010; lock = (b < 3) ? 4'b0010 : 4'b0000; #1;
      chk("lk_burst_gnt", 64'(gnt), 64'h2);
    end
    next_cyc(); req = 4'b1000; lock = '0; #1;
    chk("lk_after_gnt", 64'(gnt), 64'h8);

    // owner idle: port 0 locked, port 2 must wait
    next_cyc(); req = 4'b0101; lock = 4'b0001; #1;
    chk("oi_lock_gnt", 64'(gnt), 64'h1);
    for (int c = 0; c < 2; c++) begin
      next_cyc(); req = 4'b0100; #1;
      chk("oi_idle_gnt", 64'(gnt), 64'h0);
      chk("oi_idle_mem_req", 64'(mem_req), 64'h0);
    end
    next_cyc(); req = 4'b0101; #1;
    chk("oi_resume_gnt", 64'(gnt), 64'h1);
    next_cyc(); req = 4'b0100; lock = '0; #1;
    chk("oi_exit_gnt", 64'(gnt), 64'h0);
    next_cyc(); #1;
    chk("oi_p2_gnt", 64'(gnt), 64'h4);

    // forced release: 16 locked grants to port 0, then one to port 1
    next_cyc(); req = 4'b0011; we = 4'b0010; lock = 4'b0001; #1;
    for (int i = 0; i < 40; i++) begin
      chk("fr_gnt", 64'(gnt), (i % 17 == 16) ? 64'h2 : 64'h1);
      next_cyc(); #1;
    end
    req = '0; we = '0; lock = '0; #1;
    chk("fr_exit_gnt", 64'(gnt), 64'h0);

    // pointer wrap from port 3 back to port 0
    next_cyc(); req = 4'b1001; #1;
    chk("wrap_p3_gnt", 64'(gnt), 64'h8);
    next_cyc(); #1;
    chk("wrap_p0_gnt", 64'(gnt), 64'h1);

    // reset during port 3 locked burst
    next_cyc(); req = 4'b1000; lock = 4'b1000; #1;
    chk("rb_lock_gnt", 64'(gnt), 64'h8);
    next_cyc(); req = 4'b1010; #1;
    chk("rb_locked_gnt", 64'(gnt), 64'h8);
    next_cyc(); #1;
    chk("rb_pre_rvalid", 64'(rvalid), 64'h8);
    chk("rb_pre_gnt", 64'(gnt), 64'h8);
    rst = 1'b1; #1;
    chk("rb_rst_rvalid", 64'(rvalid), 64'h0);
    chk("rb_rst_gnt", 64'(gnt), 64'h2);
    next_cyc(); rst = 1'b0; req = 4'b1001; lock = '0; #1;
    chk("rb_post_gnt", 64'(gnt), 64'h1);

    next_cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpsoc_spram_arbiter.md
# mpsoc_spram_arbiter

Round-robin arbiter that shares one single-port SRAM memory port between `NUM_PORTS` requesters, typically several AXI4-to-SRAM bridges and a DMA engine. Each requester drives the bridge-style memory request bundle `req/we/addr/be/data`. The arbiter grants one requester per cycle, muxes its request onto the SRAM, and returns read data with a registered per-port valid. A per-port lock input keeps ownership for the length of a burst, and a bounded lock counter prevents starvation.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesters (≥1).
- `ADDR_WIDTH`, 64: address width.
- `DATA_WIDTH`, 64: data width; byte-enable width is `DATA_WIDTH/8`.
- `MAX_LOCK`, 16: maximum consecutive locked grants before forced release (≥1).

Ports:
- `clk_i`  in  1: clock. The block has one clock; reset is asynchronous and active-high.
- `rst_i`  in  1: asynchronous reset, active-high.
- `req_i`  in  NUM_PORTS: per-port request.
- `we_i`  in  NUM_PORTS: per-port write enable.
- `lock_i`  in  NUM_PORTS: per-port lock request; held high for the duration of a burst.
- `addr_i`  in  NUM_PORTS*ADDR_WIDTH: per-port address; port k occupies slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- `be_i`  in  NUM_PORTS*DATA_WIDTH/8: per-port byte enables.
- `wdata_i`  in  NUM_PORTS*DATA_WIDTH: per-port write data.
- `gnt_o`  out  NUM_PORTS: one-hot grant, combinational.
- `rvalid_o`  out  NUM_PORTS: read data valid for port k, registered.
- `rdata_o`  out  DATA_WIDTH: read data, shared by all ports and equal to `mem_data_i`.
- `mem_req_o`  out  1: request to SRAM.
- `mem_we_o`  out  1: write enable to SRAM.
- `mem_addr_o`  out  ADDR_WIDTH: SRAM address.
- `mem_be_o`  out  DATA_WIDTH/8: SRAM byte enables.
- `mem_data_o`  out  DATA_WIDTH: SRAM write data.
- `mem_data_i`  in  DATA_WIDTH: SRAM read data, valid one cycle after the request.

## Operation
- Registers:
  - `state_q` ∈ {UNLOCKED, LOCKED}.
  - `rr_ptr_q`: $clog2(NUM_PORTS) bits, minimum 1.
  - `owner_q`: same width as `rr_ptr_q`.
  - `lock_cnt_q`: $clog2(MAX_LOCK+1) bits.
  - `rvalid_q`: NUM_PORTS bits.
- UNLOCKED:
  - The grant goes to the first k with `req_i[k]=1`, searching from `rr_ptr_q` upward and wrapping from NUM_PORTS-1 to 0.
  - On a grant to port k, `rr_ptr_q` becomes (k+1) mod NUM_PORTS.
  - If `lock_i[k]=1` at the grant: state becomes LOCKED, `owner_q` becomes k, `lock_cnt_q` becomes 1.
- LOCKED:
  - Only `owner_q` can be granted. If the owner's `req_i` is 0, nothing is granted and `mem_req_o` is 0. Other requesters wait.
  - Each owner grant increments `lock_cnt_q`.
  - Exit to UNLOCKED occurs when either of these holds (evaluated each cycle):
    - `lock_i[owner]=0`. The current-cycle owner request, if any, is still granted.
    - A grant occurs while `lock_cnt_q == MAX_LOCK` (forced release).
  - On exit, `lock_cnt_q` becomes 0 and `rr_ptr_q` becomes owner+1. The next cycle arbitrates normally, and the former owner wins only if no other port requests.
- Memory mux:
  - `mem_req_o` = OR of `gnt_o`.
  - `mem_we_o`, `mem_addr_o`, `mem_be_o` and `mem_data_o` come from the granted port's slices.
  - With no grant, all `mem_*` outputs are 0.
- Read return:
  - `rvalid_q[k]` is set to `gnt_o[k] & ~we_i[k]` each cycle. `rvalid_o = rvalid_q`.
  - `rdata_o = mem_data_i`, unregistered.
- Writes return no response. The grant cycle is the write cycle.
- NUM_PORTS=1: the single port is granted whenever it requests. Lock logic still counts, and forced release is a no-op re-arbitration.

## Timing
- Reset (asynchronous on `rst_i` high): state UNLOCKED, `rr_ptr_q`=0, `owner_q`=0, `lock_cnt_q`=0, `rvalid_o`=0. Combinational outputs follow the inputs (all 0 when no `req_i`).
- Reset mid-burst: lock and ownership are dropped immediately, and any pending `rvalid` is cleared.
- Grant latency: 0 cycles. `gnt_o` is asserted in the same cycle as `req_i` when the port wins.
- A requester holds `req/we/addr/be/wdata` stable until it sees `gnt_o`.
- Read latency: `rvalid_o[k]` and `rdata_o` are valid exactly 1 cycle after the grant cycle.
- Back-to-back reads from different ports give back-to-back `rvalid_o` bits, each on its own port.
- Throughput: one grant per cycle, so 100% memory utilisation under continuous requests.
- Fairness: unlocked, a port waits at most NUM_PORTS-1 grants. Locked, the worst-case wait is (NUM_PORTS-1)·MAX_LOCK grants plus owner idle cycles.
- Simultaneous events on exit:
  - If the owner drops `lock_i` in the same cycle another port requests, the owner is served that cycle if it requests.
  - The other port is granted in the following cycle.

## Test plan
- Reset state: assert `rst_i` with all `req_i` high → `gnt_o=4'b0001`, `rvalid_o=0`. Release reset, then hold `req_i=4'b1111` for 8 cycles → grants 0,1,2,3,0,1,2,3.
- Read return: port 2 reads addr 0x40 with the SRAM model returning 0xDEAD_BEEF → `gnt_o=4'b0100` in cycle t; in t+1, `rvalid_o=4'b0100` and `rdata_o=0xDEAD_BEEF`. A write from port 1 in t+1 gives no `rvalid`.
- Lock hold: port 1 holds `lock_i`/`req_i` for a 4-beat burst while port 3 requests continuously → port 1 is granted 4 consecutive cycles, and port 3 is granted the cycle after `lock_i[1]` falls.
- Owner idle: port 0 is locked and drops `req_i` for 2 cycles while port 2 requests → `gnt_o=0` and `mem_req_o=0` for those 2 cycles. Port 2 is not granted.
- Forced release: MAX_LOCK=16, port 0 locked and requesting for 40 cycles, port 1 requesting → port 0 gets 16 grants, port 1 gets 1, port 0 is re-locked for 16, port 1 gets 1, and so on.
- Pointer wrap and reset mid-burst: with port 3 granted, `rr_ptr` wraps to 0 → the next grant with `req_i=4'b1001` goes to port 0. Assert `rst_i` during port 3's locked burst → the lock clears and `rr_ptr=0` after reset.
